// File: rtl/demux_1_para_4_reg.sv
// Registered 1-to-4 demux with per-channel 1-entry valid/ready holding registers.
// Optional `DEMUX_ROUND_ROBIN_EN: channel chosen by an internal rotating pointer instead of S.
module demux_1_para_4_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [15:0]      xfer_cnt
);

  logic [3:0]            valid_q, valid_d;
  logic [3:0][WIDTH-1:0] data_q, data_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [3:0]            pop;
  logic [1:0]            ch;
  logic                  accept;

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] rr_q, rr_d;
  logic       unused_s;

  assign unused_s = ^S;
  assign ch       = rr_q;

  // Pointer only moves on an accept, so a stalled channel holds the order.
  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = rr_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 2'd0;
    else       rr_q <= rr_d;
  end
`else
  assign ch = S;
`endif

  assign pop      = valid_q & out_ready;
  assign in_ready = ~valid_q[ch] | out_ready[ch];
  assign accept   = in_valid & in_ready;

  // Accept overrides a same-channel pop, keeping valid high with no bubble.
  always_comb begin
    valid_d = valid_q & ~pop;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d[ch] = 1'b1;
      data_d[ch]  = D;
      cnt_d       = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign Y0        = data_q[0];
  assign Y1        = data_q[1];
  assign Y2        = data_q[2];
  assign Y3        = data_q[3];
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1_para_4_reg.sv
// Bench for demux_1_para_4_reg: directed vector table plus randomized
// traffic checked against a per-channel slot model.
module tb_demux_1_para_4_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  D;
  logic [1:0]  S;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Y0, Y1, Y2, Y3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] xfer_cnt;

  demux_1_para_4_reg #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .D(D), .S(S),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .out_valid(out_valid), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: four slots, each either empty or holding one word.
  bit   [3:0] m_valid = '0;
  logic [7:0] m_data [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  int         m_cnt = 0;
  int         m_rr  = 0;
  logic       rdy_seen;

  task automatic step(bit r, logic [7:0] d, logic [1:0] s,
                      bit iv, logic [3:0] ordy);
    int  c;
    bit  rdy;
    @(negedge clk);
    reset = r; D = d; S = s; in_valid = iv; out_ready = ordy;
    #1;
`ifdef DEMUX_ROUND_ROBIN_EN
    c = m_rr;
`else
    c = int'(s);
`endif
    rdy = !m_valid[c] || ordy[c];
    rdy_seen = in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (r) begin
      m_valid = '0;
      for (int i = 0; i < 4; i++) m_data[i] = 8'h0;
      m_cnt = 0;
      m_rr  = 0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && ordy[i]) m_valid[i] = 1'b0;
      if (iv && rdy) begin
        m_data[c]  = d;
        m_valid[c] = 1'b1;
        m_cnt      = (m_cnt + 1) % 65536;
        m_rr       = (m_rr + 1) % 4;
      end
    end
    #1;
    chk("out_valid", {28'd0, out_valid}, {28'd0, m_valid});
    chk("xfer_cnt", {16'd0, xfer_cnt}, m_cnt);
    chk("Y0", {24'd0, Y0}, {24'd0, m_data[0]});
    chk("Y1", {24'd0, Y1}, {24'd0, m_data[1]});
    chk("Y2", {24'd0, Y2}, {24'd0, m_data[2]});
    chk("Y3", {24'd0, Y3}, {24'd0, m_data[3]});
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] d;
    logic [1:0] s;
    bit         iv;
    logic [3:0] ordy;
    bit         e_rdy;
    logic [3:0] e_valid;
    logic [15:0] e_cnt;
    logic [31:0] e_y;
  } vec_t;

  vec_t tbl [17];

  initial begin
    reset = 1'b1; D = '0; S = '0; in_valid = 1'b0; out_ready = '0;
    @(posedge clk);
    @(posedge clk);

`ifndef DEMUX_ROUND_ROBIN_EN
    // e_y packs {Y3,Y2,Y1,Y0}
    tbl[0]  = '{1, 8'hFF, 2'd0, 1, 4'b0000, 1, 4'b0000, 16'd0, 32'h00000000};
    tbl[1]  = '{1, 8'hFE, 2'd3, 1, 4'b0000, 1, 4'b0000, 16'd0, 32'h00000000};
    tbl[2]  = '{0, 8'hA0, 2'd0, 1, 4'b1111, 1, 4'b0001, 16'd1, 32'h000000A0};
    tbl[3]  = '{0, 8'hA1, 2'd1, 1, 4'b1111, 1, 4'b0010, 16'd2, 32'h0000A1A0};
    tbl[4]  = '{0, 8'hA2, 2'd2, 1, 4'b1111, 1, 4'b0100, 16'd3, 32'h00A2A1A0};
    tbl[5]  = '{0, 8'hA3, 2'd3, 1, 4'b1111, 1, 4'b1000, 16'd4, 32'hA3A2A1A0};
    tbl[6]  = '{0, 8'h11, 2'd2, 1, 4'b0000, 1, 4'b1100, 16'd5, 32'hA311A1A0};
    tbl[7]  = '{0, 8'h22, 2'd2, 1, 4'b0000, 0, 4'b1100, 16'd5, 32'hA311A1A0};
    tbl[8]  = '{0, 8'h22, 2'd2, 1, 4'b0100, 1, 4'b1100, 16'd6, 32'hA322A1A0};
    tbl[9]  = '{0, 8'h55, 2'd1, 1, 4'b0000, 1, 4'b1110, 16'd7, 32'hA32255A0};
    tbl[10] = '{0, 8'h66, 2'd1, 1, 4'b0010, 1, 4'b1110, 16'd8, 32'hA32266A0};
    tbl[11] = '{0, 8'h00, 2'd0, 0, 4'b0110, 1, 4'b1000, 16'd8, 32'hA32266A0};
    tbl[12] = '{0, 8'h77, 2'd0, 1, 4'b0000, 1, 4'b1001, 16'd9, 32'hA3226677};
    tbl[13] = '{1, 8'h99, 2'd0, 1, 4'b0000, 0, 4'b0000, 16'd0, 32'h00000000};
    tbl[14] = '{0, 8'h5A, 2'd3, 1, 4'b0000, 1, 4'b1000, 16'd1, 32'h5A000000};
    tbl[15] = '{0, 8'h5B, 2'd3, 1, 4'b0000, 0, 4'b1000, 16'd1, 32'h5A000000};
    tbl[16] = '{0, 8'h5B, 2'd1, 1, 4'b0000, 1, 4'b1010, 16'd2, 32'h5A005B00};
    m_valid = '0;
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].d, tbl[i].s, tbl[i].iv, tbl[i].ordy);
      chk($sformatf("vec%0d_rdy", i), {31'd0, rdy_seen}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("vec%0d_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d_cnt", i), {16'd0, xfer_cnt}, {16'd0, tbl[i].e_cnt});
      chk($sformatf("vec%0d_y", i), {Y3, Y2, Y1, Y0}, tbl[i].e_y);
    end
`else
    step(1, 8'h0, 2'd0, 0, 4'b0000);
    for (int k = 1; k <= 4; k++) step(0, 8'(k), 2'd3, 1, 4'b0000);
    chk("rr_first4", {Y3, Y2, Y1, Y0}, 32'h04030201);
    step(0, 8'd5, 2'd3, 1, 4'b1111);
    step(0, 8'd6, 2'd3, 1, 4'b1111);
    chk("rr_y0_5", {24'd0, Y0}, 32'd5);
    chk("rr_y1_6", {24'd0, Y1}, 32'd6);
    step(0, 8'd7, 2'd3, 1, 4'b0000);
    step(0, 8'd8, 2'd3, 1, 4'b0000);
    step(0, 8'd9, 2'd3, 1, 4'b0000);
    step(0, 8'd10, 2'd3, 1, 4'b0000);
    chk("rr_stall_rdy", {31'd0, rdy_seen}, 32'd0);
    step(0, 8'd10, 2'd0, 1, 4'b0010);
    chk("rr_after_stall", {24'd0, Y1}, 32'd10);
`endif

    step(1, 8'h0, 2'd0, 0, 4'b0000);
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 49) == 0, 8'($urandom), 2'($urandom),
           $urandom_range(0, 3) != 0, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
